cell_sweep_capture: RTL and testbench
=====================================

# cell_sweep_capture

Stimulus-and-capture stage wrapped around the standard-cell characterisation array. It walks the array's 6-bit input through all 64 patterns in Gray-code order and samples the 73-bit array output after a settle delay. Each sample is folded into a sticky toggle mask that flags stuck outputs, and optionally into a 32-bit MISR signature. Both results are then streamed out as bytes over a valid/ready port to the tile's readout logic.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles `cell_in` is held before sampling. Legal range 1..255.
- `MISR_POLY`, default 32'h04C11DB7: MISR feedback polynomial.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset. Synchronous, active-high.
- `start` in 1: begins a sweep. Accepted only in IDLE or DONE.
- `busy` out 1: high from the cycle after `start` is accepted until DONE.
- `done` out 1: high in DONE. Held until the next accepted `start` or `rst`.
- `cell_in` out 6: stimulus to the cell array.
- `cell_out` in 73: response from the cell array.
- `rd_valid` out 1: readout byte valid.
- `rd_ready` in 1: readout byte accepted.
- `rd_data` out 8: readout byte.

## Operation
- States: IDLE, DRIVE, SAMPLE, DUMP, DONE.
- IDLE/DONE, `start`=1:
  - `idx` ← 0, `mask` ← 0, `misr` ← 32'hFFFFFFFF, `first` ← 1.
  - Go to DRIVE with `settle_cnt` ← 0.
- DRIVE:
  - `cell_in` = `idx ^ (idx>>1)` (Gray code), so exactly one input bit changes per step. This is required for the clock/gate inputs of the sequential cells.
  - Stay until `settle_cnt` = SETTLE_CYCLES-1, then go to SAMPLE.
- SAMPLE (one cycle, `cell_in` unchanged):
  - `prev` ← `cell_out`.
  - If `first`=0: `mask` ← `mask | (cell_out ^ prev)`.
  - `first` ← 0.
  - MISR update (when enabled):
    - `fold` = `cell_out[31:0] ^ cell_out[63:32] ^ {23'b0, cell_out[72:64]}`.
    - `misr` ← `{misr[30:0],1'b0} ^ (misr[31] ? MISR_POLY : 0) ^ fold`.
  - If `idx`=63, go to DUMP with `byte_idx` ← 0. Otherwise `idx`+1 and return to DRIVE.
- DUMP byte order:
  - Bytes 0..8: `mask[8k+7:8k]`.
  - Byte 9: `{7'b0, mask[72]}`.
  - Bytes 10..13 (MISR builds only): `misr`, LSB byte first.
  - Go to DONE after the transfer of the final byte.
- Handshake:
  - A transfer occurs on `rd_valid & rd_ready`.
  - `rd_valid` stays high and `rd_data` stays stable until the transfer.
  - `rd_valid` never drops without a transfer, except on `rst`.
- `start` during DRIVE/SAMPLE/DUMP is ignored.
- `cell_in` = 0 in IDLE, DUMP and DONE.
- Reset values, applied on any cycle including mid-sweep or mid-dump:
  - State IDLE.
  - `busy`=0, `done`=0, `rd_valid`=0, `rd_data`=0, `cell_in`=0.
  - `mask`=0, `misr`=32'hFFFFFFFF.
  - Partial results are discarded.

## Timing
- `start` sampled high at edge 0. DRIVE occupies edges 1..SETTLE_CYCLES.
- Each pattern takes SETTLE_CYCLES+1 cycles.
- First `rd_valid` is high at edge 64·(SETTLE_CYCLES+1)+1. This is 321 for the default SETTLE_CYCLES.
- With `rd_ready` tied high, one byte transfers per cycle. DONE is reached one cycle after the last transfer.
- `cell_out` is sampled directly, without a synchroniser. SETTLE_CYCLES covers the propagation of the array, including the delay cells.

## Configuration
- Macro: `CELL_SWEEP_MISR_EN`.
- Defined:
  - MISR register and update logic are present.
  - DUMP emits 14 bytes.
- Undefined:
  - No MISR logic; `MISR_POLY` is unused.
  - DUMP emits 10 bytes (mask only).

## Structure
- `cell_sweep_pkg` holds:
  - State enum.
  - `MASK_BYTES`=10, `SIG_BYTES`=4.
  - Default polynomial.
  - Gray-code function.
- `cell_sweep_misr` is the only sub-module: 32-bit fold-and-shift register with `clk`, `rst`, `en`, `init`, `data[72:0]`, `sig[31:0]`. It is instantiated only under `CELL_SWEEP_MISR_EN`.

## Test plan
- `cell_out` tied to 0, `rd_ready`=1:
  - 10 bytes of 0x00.
  - MISR build: signature equals the reference model for 64 zero samples.
  - `done`=1 afterwards.
- `cell_out` = `{67'b0, cell_in}`:
  - Byte 0 = 0x3F, bytes 1..9 = 0x00.
  - `cell_in` sequence matches Gray code, 0,1,3,2,…,32, with a single-bit change per step.
- `cell_out[72]` toggled once mid-sweep, all other bits 0: byte 9 = 0x01, all other mask bytes 0x00.
- Backpressure, `rd_ready` low for 5 cycles on byte 3: `rd_valid` stays 1 and `rd_data` stays stable; the byte count is still 10 (or 14).
- Timing with SETTLE_CYCLES=4: first `rd_valid` at edge 321; `start` pulses at edges 50 and 200 change nothing.
- `rst` asserted at pattern `idx`=20:
  - Next edge: `cell_in`=0, `busy`=0, state IDLE.
  - A subsequent `start` produces results identical to a clean run.

Source files
------------

// File: rtl/cell_sweep_pkg.sv
// Shared types and constants for the cell-array sweep/capture stage.
// The optional MISR signature path is enabled by defining CELL_SWEEP_MISR_EN.
package cell_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DUMP   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int          MASK_BYTES        = 10;
  localparam int          SIG_BYTES         = 4;
  localparam int          CELL_IN_W         = 6;
  localparam int          CELL_OUT_W        = 73;
  localparam logic [31:0] DEFAULT_MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED         = 32'hFFFF_FFFF;

  // Binary-reflected Gray code: successive indices differ in exactly one bit.
  function automatic logic [CELL_IN_W-1:0] gray6(input logic [CELL_IN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/cell_sweep_misr.sv
// 32-bit fold-and-shift signature register over the 73-bit array response.
// Only instantiated when CELL_SWEEP_MISR_EN is defined.
module cell_sweep_misr
  import cell_sweep_pkg::*;
#(
  parameter logic [31:0] POLY = DEFAULT_MISR_POLY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  init,
  input  logic [CELL_OUT_W-1:0] data,
  output logic [31:0]           sig
);

  logic [31:0] sig_q;
  logic [31:0] sig_d;
  logic [31:0] fold;

  // The 73 response bits are XOR-folded to 32 before entering the shift path.
  assign fold = data[31:0] ^ data[63:32] ^ {23'b0, data[72:64]};

  always_comb begin
    sig_d = sig_q;
    if (init) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/cell_sweep_capture.sv
// Gray-code stimulus sweep of the cell array with sticky toggle-mask capture and
// byte readout; optional MISR signature when CELL_SWEEP_MISR_EN is defined.
module cell_sweep_capture
  import cell_sweep_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [31:0] MISR_POLY     = DEFAULT_MISR_POLY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [CELL_IN_W-1:0]  cell_in,
  input  logic [CELL_OUT_W-1:0] cell_out,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [7:0]            rd_data
);

`ifdef CELL_SWEEP_MISR_EN
  localparam int NUM_BYTES = MASK_BYTES + SIG_BYTES;
`else
  localparam int NUM_BYTES = MASK_BYTES;
`endif
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_BYTE   = 4'(NUM_BYTES - 1);

  state_e                state_q,      state_d;
  logic [CELL_IN_W-1:0]  idx_q,        idx_d;
  logic [7:0]            settle_cnt_q, settle_cnt_d;
  logic [3:0]            byte_idx_q,   byte_idx_d;
  logic [CELL_OUT_W-1:0] mask_q,       mask_d;
  logic [CELL_OUT_W-1:0] prev_q,       prev_d;
  logic                  first_q,      first_d;

  logic                  start_ok;
  logic [127:0]          dump_vec;

  assign start_ok = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    byte_idx_d   = byte_idx_q;
    mask_d       = mask_q;
    prev_d       = prev_q;
    first_d      = first_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d        = '0;
          mask_d       = '0;
          first_d      = 1'b1;
          settle_cnt_d = '0;
          state_d      = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      ST_SAMPLE: begin
        // The very first sample only seeds prev; it has nothing to compare against.
        prev_d  = cell_out;
        first_d = 1'b0;
        if (!first_q) begin
          mask_d = mask_q | (cell_out ^ prev_q);
        end
        if (idx_q == 6'd63) begin
          byte_idx_d = '0;
          state_d    = ST_DUMP;
        end else begin
          idx_d        = idx_q + 6'd1;
          settle_cnt_d = '0;
          state_d      = ST_DRIVE;
        end
      end
      ST_DUMP: begin
        if (rd_ready) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d = ST_DONE;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      byte_idx_q   <= '0;
      mask_q       <= '0;
      prev_q       <= '0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      byte_idx_q   <= byte_idx_d;
      mask_q       <= mask_d;
      prev_q       <= prev_d;
      first_q      <= first_d;
    end
  end

`ifdef CELL_SWEEP_MISR_EN
  logic [31:0] sig;

  cell_sweep_misr #(
    .POLY (MISR_POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_SAMPLE),
    .init (start_ok),
    .data (cell_out),
    .sig  (sig)
  );

  assign dump_vec = {16'b0, sig, 7'b0, mask_q};
`else
  logic unused_misr_cfg;

  assign unused_misr_cfg = ^{MISR_POLY, start_ok};
  assign dump_vec        = {55'b0, mask_q};
`endif

  // Readout bytes are little-endian slices of one flat vector; mask and
  // signature are frozen during DUMP so rd_data is stable until accepted.
  assign busy     = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE) || (state_q == ST_DUMP);
  assign done     = (state_q == ST_DONE);
  assign cell_in  = ((state_q == ST_DRIVE) || (state_q == ST_SAMPLE)) ? gray6(idx_q) : '0;
  assign rd_valid = (state_q == ST_DUMP);
  assign rd_data  = (state_q == ST_DUMP) ? dump_vec[{byte_idx_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_cell_sweep_capture.sv
// Directed bench for cell_sweep_capture: zero, walking, single-toggle and
// backpressure sweeps plus mid-sweep reset; MISR bytes checked under CELL_SWEEP_MISR_EN.
module tb_cell_sweep_capture;

`ifdef CELL_SWEEP_MISR_EN
  localparam int NUM_BYTES = 14;
`else
  localparam int NUM_BYTES = 10;
`endif
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rd_ready = 1'b1;
  logic [72:0] cell_out;
  logic        busy;
  logic        done;
  logic [5:0]  cell_in;
  logic        rd_valid;
  logic [7:0]  rd_data;

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          mode_sel = 0;
  logic        flag72 = 1'b0;
  logic [7:0]  exp_q[$];

  cell_sweep_capture dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cell_in  (cell_in),
    .cell_out (cell_out),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cell array stand-in
  always @(negedge clk) begin
    if (!busy) flag72 <= 1'b0;
    else if (mode_sel == 2 && cell_in == 6'h30) flag72 <= 1'b1;
  end

  always @* begin
    case (mode_sel)
      1:       cell_out = {67'b0, cell_in};
      2:       cell_out = {flag72, 72'b0};
      default: cell_out = 73'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] gray(input logic [5:0] b);
    return b ^ {1'b0, b[5:1]};
  endfunction

  function automatic logic [72:0] cell_val(input int mode, input int i);
    logic [5:0] ii;
    ii = 6'(i);
    case (mode)
      1:       return {67'b0, gray(ii)};
      2:       return (i >= 32) ? {1'b1, 72'b0} : 73'b0;
      default: return 73'b0;
    endcase
  endfunction

  // hand-derived toggle-mask bytes per stimulus mode
  function automatic logic [7:0] exp_mask_byte(input int mode, input int k);
    if (mode == 1 && k == 0) return 8'h3F;
    if (mode == 2 && k == 9) return 8'h01;
    return 8'h00;
  endfunction

  function automatic logic [31:0] misr_model(input int mode);
    logic [31:0] m;
    logic [72:0] co;
    logic [31:0] fold;
    m = 32'hFFFF_FFFF;
    for (int i = 0; i < 64; i++) begin
      co   = cell_val(mode, i);
      fold = co[31:0] ^ co[63:32] ^ {23'b0, co[72:64]};
      m    = {m[30:0], 1'b0} ^ (m[31] ? POLY : 32'h0) ^ fold;
    end
    return m;
  endfunction

  task automatic run_sweep(input int mode, input int bp_byte);
    int         t0, k, first_edge, nbytes, hold, step;
    logic [5:0] prev_ci;
    logic [7:0] held;
    logic [31:0] sig;
    bit         fin;
    mode_sel = mode;
    exp_q.delete();
    for (int b = 0; b < 10; b++) exp_q.push_back(exp_mask_byte(mode, b));
    sig = misr_model(mode);
`ifdef CELL_SWEEP_MISR_EN
    for (int b = 0; b < 4; b++) exp_q.push_back(sig[8*b +: 8]);
`endif
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    first_edge = -1; nbytes = 0; hold = 0; step = 0; prev_ci = 6'd0; held = 8'h00; fin = 1'b0;
    for (int c = 0; c < 1000 && !fin; c++) begin
      @(negedge clk);
      k = cyc - t0;
      start = (k == 49 || k == 199);
      if (busy && !rd_valid && cell_in !== prev_ci) begin
        step++;
        chk("gray_seq", 32'(cell_in), 32'(gray(6'(step))));
        chk("gray_one_bit", 32'($countones(cell_in ^ prev_ci)), 32'd1);
        prev_ci = cell_in;
      end
      if (rd_valid) begin
        if (first_edge < 0) first_edge = k + 1;
        if (nbytes == bp_byte && hold < 5) begin
          if (hold == 0) held = rd_data;
          else chk("bp_data_stable", 32'(rd_data), 32'(held));
          hold++;
          rd_ready = 1'b0;
        end else begin
          rd_ready = 1'b1;
          if (exp_q.size() == 0) chk("extra_byte", 32'(rd_data), 32'hDEAD);
          else chk($sformatf("byte%0d", nbytes), 32'(rd_data), 32'(exp_q.pop_front()));
          nbytes++;
        end
      end else begin
        rd_ready = 1'b1;
        if (nbytes == bp_byte && hold > 0) chk("bp_valid_held", 32'(rd_valid), 32'd1);
        if (done) fin = 1'b1;
      end
    end
    start    = 1'b0;
    rd_ready = 1'b1;
    chk("sweep_finished", 32'(fin), 32'd1);
    chk("first_valid_edge", 32'(first_edge), 32'd321);
    chk("byte_count", 32'(nbytes), 32'(NUM_BYTES));
    chk("gray_steps", 32'(step), 32'd63);
    if (bp_byte >= 0) chk("bp_cycles", 32'(hold), 32'd5);
    chk("done_after", 32'(done), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("cell_in_after", 32'(cell_in), 32'd0);
  endtask

  task automatic reset_mid_sweep();
    bit hit;
    mode_sel = 1;
    hit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      @(negedge clk);
      if (busy && cell_in == gray(6'd20)) hit = 1'b1;
    end
    chk("reach_idx20", 32'(hit), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_cell_in", 32'(cell_in), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_cell_in", 32'(cell_in), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, -1);
    run_sweep(1, -1);
    run_sweep(2, -1);
    run_sweep(1, 3);
    reset_mid_sweep();
    run_sweep(1, -1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
